// File: rtl/rd_req_issuer_if.sv
// rtl/rd_req_issuer_if.sv - request, target strobe and response signals of the read issuer
interface rd_req_issuer_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;

  // issuer side
  modport master (
    input  req_valid, req_addr, rdata,
    output req_ready, rd, addr, rsp_valid, rsp_data, rsp_addr
  );

  // producer / target / response consumer side
  modport slave (
    output req_valid, req_addr, rdata,
    input  req_ready, rd, addr, rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/rd_req_issuer.sv
// rtl/rd_req_issuer.sv - buffers read requests and issues them as two-edge rd strobes
module rd_req_issuer #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  rd_req_issuer_if.master bus,
  output logic            busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD1, S_RD2, S_GAP} state_t;

  state_t          state_q, state_d;
  logic            rd_q, rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [AW-1:0]   rsp_addr_q, rsp_addr_d;
  logic            req_ready_q, req_ready_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [AW-1:0]   fifo_q [DEPTH];
  logic            push, pop;

  // Next-state logic: FIFO bookkeeping and the strobe sequencer (launch only from IDLE)
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    gap_cnt_d   = gap_cnt_q;
    pop         = 1'b0;
    push        = bus.req_valid && req_ready_q;

    case (state_q)
      S_IDLE: begin
        rd_d = 1'b0;
        if (ce && (count_q != '0)) begin
          pop     = 1'b1;
          addr_d  = fifo_q[rd_ptr_q];
          rd_d    = 1'b1;
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        rd_d    = 1'b1;
        state_d = S_RD2;
      end
      S_RD2: begin
        rd_d        = 1'b0;
        rsp_data_d  = bus.rdata;
        rsp_addr_d  = addr_q;
        rsp_valid_d = 1'b1;
        gap_cnt_d   = GW'(GAP - 1);
        state_d     = S_GAP;
      end
      S_GAP: begin
        rd_d = 1'b0;
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: begin
        rd_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    // full this cycle blocks pushes even if a pop frees a slot: no bypass
    req_ready_d = (count_d != FULL_CNT);
  end

  // Control and output registers; reset aborts any read in flight without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      req_ready_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      req_ready_q <= req_ready_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Request storage; contents are don't-care until the count says otherwise
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.req_addr;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rd        = rd_q;
  assign bus.addr      = addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_rd_req_issuer.sv
// tb/tb_rd_req_issuer.sv - scoreboard bench for rd_req_issuer
module tb_rd_req_issuer;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;
  logic busy;

  rd_req_issuer_if #(.AW(8), .DW(8)) bus ();

  rd_req_issuer #(.AW(8), .DW(8), .DEPTH(4), .GAP(GAP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ce   (ce),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Target model: valid data only during the second rd cycle, garbage otherwise
  int tgt_hi = 0;
  always @(negedge clk) begin
    if (!rst_n || !bus.rd) tgt_hi = 0;
    else tgt_hi++;
    bus.rdata = (tgt_hi == 2) ? (bus.addr ^ 8'h99) : 8'hEE;
  end

  // Response monitor: pops the scoreboard whenever rsp_valid is presented
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got addr 0x%0h data 0x%0h, required no response",
                 bus.rsp_addr, bus.rsp_data);
      end else begin
        e = exp_q.pop_front();
        check("rsp_addr", bus.rsp_addr, e[15:8]);
        check("rsp_data", bus.rsp_data, e[7:0]);
      end
    end
  end

  // Strobe monitor: two-edge rd pulses, low gap between reads, addr stability
  int hi_run = 0;
  int lo_run = 0;
  bit had_read = 0;
  logic [7:0] launch_addr;
  always @(negedge clk) begin
    if (!rst_n) begin
      hi_run = 0;
      lo_run = 0;
      had_read = 0;
    end else if (bus.rd) begin
      if (hi_run == 0) begin
        launch_addr = bus.addr;
        if (had_read) check("gap_low_edges_ge_GAP", 32'(lo_run >= GAP), 1);
      end else begin
        check("addr_stable_during_rd", bus.addr, launch_addr);
      end
      hi_run++;
    end else begin
      if (hi_run != 0) begin
        check("rd_high_edges", hi_run, 2);
        check("addr_stable_after_rd_fall", bus.addr, launch_addr);
        had_read = 1;
        lo_run = 0;
      end
      hi_run = 0;
      lo_run++;
    end
  end

  task automatic push_req(input logic [7:0] a, input logic [7:0] d, input bit expect_rsp);
    int n = 0;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("push_accept_timeout", 0, 1);
    end else begin
      if (expect_rsp) exp_q.push_back({a, d});
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", busy, 0);
    check("scoreboard_empty_at_idle", exp_q.size(), 0);
  endtask

  logic [7:0] wrap_exp [10] = '{8'h99, 8'h98, 8'h9B, 8'h9A, 8'h9D,
                                8'h9C, 8'h9F, 8'h9E, 8'h91, 8'h90};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n         = 1'b1;
    ce            = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'h00;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rd", bus.rd, 0);
    check("reset_addr", bus.addr, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_addr", bus.rsp_addr, 0);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    #1 check("req_ready_before_first_edge", bus.req_ready, 0);
    @(negedge clk);
    check("req_ready_after_first_edge", bus.req_ready, 1);

    // Single read with latency checks
    ce = 1'b1;
    push_req(8'h3C, 8'hA5, 1);
    check("single_no_launch_at_push_edge", bus.rd, 0);
    @(negedge clk);
    check("single_rd_edge2", bus.rd, 1);
    check("single_addr", bus.addr, 8'h3C);
    @(negedge clk);
    check("single_rd_edge3", bus.rd, 1);
    check("single_no_early_rsp", bus.rsp_valid, 0);
    @(negedge clk);
    check("single_rd_fell", bus.rd, 0);
    check("single_rsp_valid", bus.rsp_valid, 1);
    @(negedge clk);
    check("single_rsp_one_cycle", bus.rsp_valid, 0);
    check("single_addr_held", bus.addr, 8'h3C);
    wait_idle(50);

    // Fill and backpressure with ce low
    ce = 1'b0;
    push_req(8'h10, 8'h89, 1);
    push_req(8'h11, 8'h88, 1);
    push_req(8'h12, 8'h8B, 1);
    push_req(8'h13, 8'h8A, 1);
    check("full_req_ready_low", bus.req_ready, 0);
    bus.req_addr  = 8'h14;
    bus.req_valid = 1'b1;
    ok = 1;
    repeat (4) begin
      @(negedge clk);
      if (bus.req_ready) ok = 0;
    end
    check("fifth_push_refused", ok, 1);
    bus.req_valid = 1'b0;
    check("ce_low_no_launch", bus.rd, 0);
    check("ce_low_busy", busy, 1);
    ce = 1'b1;
    wait_idle(200);

    // ce dropped during RD1
    ce = 1'b0;
    push_req(8'h20, 8'hB9, 1);
    push_req(8'h21, 8'hB8, 1);
    ce = 1'b1;
    @(negedge clk);
    check("ce_drop_launched", bus.rd, 1);
    check("ce_drop_addr", bus.addr, 8'h20);
    ce = 1'b0;
    repeat (12) @(negedge clk);
    check("ce_drop_one_completed", exp_q.size(), 1);
    check("ce_drop_second_held", bus.rd, 0);
    check("ce_drop_busy", busy, 1);
    ce = 1'b1;
    wait_idle(100);

    // Async reset during RD2
    ce = 1'b0;
    push_req(8'h30, 8'h00, 0);
    push_req(8'h31, 8'h00, 0);
    ce = 1'b1;
    @(negedge clk);
    check("rst_mid_rd1", bus.rd, 1);
    @(negedge clk);
    check("rst_mid_rd2", bus.rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_rd_dropped", bus.rd, 0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_req_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (bus.rd || busy) ok = 0;
    end
    check("rst_fifo_flushed", ok, 1);
    check("rst_req_ready_back", bus.req_ready, 1);

    // Wrap-around: ten sequential reads through a four-entry FIFO
    for (int i = 0; i < 10; i++) push_req(8'(i), wrap_exp[i], 1);
    wait_idle(300);

    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
